amcxfif_rstseq: RTL and testbench
=================================

# amcxfif_rstseq

Soft-reset sequencer for the FIFO clock/reset block, on the AHB host clock. On a host request it drives per-domain soft-reset requests into the FIFO clock/reset synchronizer. It then waits for each domain's synchronized reset to echo back, asserted and later released, and reports completion or timeout. It is the initiating end of the soft-reset path the clock/reset block receives.

## Interface
- NUM_DOM, 5 — number of reset domains (rx sys, tx sys, rx fab, tx fab, stats)
- HOLD_CYC, 16 — hclk cycles soft reset is held after all acks seen (≥1)
- TIMEOUT_CYC, 1023 — max hclk cycles spent in either wait state (≥1)
- SYNC_STAGES, 2 — flops in ack synchronizer (≥2)

Ports:
- hclk  in  1  host clock; the only clock
- hresetn  in  1  reset, asynchronous, active-low
- rst_req  in  1  start request; sampled only in IDLE, level or pulse
- rst_mask  in  NUM_DOM  domains to reset; latched on accept
- soft_rst_o  out  NUM_DOM  per-domain soft reset request, registered
- dom_rst_ack  in  NUM_DOM  each domain's synchronized reset; asynchronous to hclk
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion, including timeout
- timeout_err  out  1  sticky; set on any wait timeout, cleared on next accept

## Operation
- States: IDLE, WAIT_SET, HOLD, WAIT_CLR, DONE. Moore outputs, all registered.
- IDLE: on rst_req=1, latch rst_mask into mask_q, clear timeout_err, go to WAIT_SET. If rst_mask=0, go straight to DONE; soft_rst_o stays 0.
- WAIT_SET: soft_rst_o=mask_q. When (ack_sync & mask_q)==mask_q, go to HOLD and load the hold counter with HOLD_CYC-1.
- HOLD: soft_rst_o=mask_q. Decrement the counter; at 0 go to WAIT_CLR.
- WAIT_CLR: soft_rst_o=0. When (ack_sync & mask_q)==0, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Timeout: a shared counter clears on entry to each wait state. After TIMEOUT_CYC cycles in a wait state without meeting its condition, set timeout_err. From WAIT_SET, go to WAIT_CLR (soft reset deasserted, HOLD skipped). From WAIT_CLR, go to DONE.
- Unmasked ack bits are ignored in every state.
- rst_req while busy is ignored and not queued. rst_mask changes while busy have no effect.
- Counters are ceil(log2) wide with no wrap. The hold counter saturates at 0, and the timeout counter stops at TIMEOUT_CYC.

## Timing
- Reset (hresetn=0, asynchronous): state=IDLE; soft_rst_o=0, busy=0, done=0, timeout_err=0. Mask, counters and synchronizer flops are all 0.
- Reset mid-operation drops soft_rst_o at once with no done pulse. Deassertion of hresetn is synchronized externally.
- Accept edge E0 (IDLE, rst_req=1, mask≠0): soft_rst_o and busy go high after E0.
- ack → ack_sync latency: SYNC_STAGES cycles.
- Acks looped back with zero delay and SYNC_STAGES=2:
  - HOLD entered at E0+3.
  - soft_rst_o falls at E0+3+HOLD_CYC, i.e. high for 3+HOLD_CYC cycles.
  - DONE entered at E0+6+HOLD_CYC.
  - busy falls at E0+7+HOLD_CYC.
- Zero mask: done high after E0+1, busy high from E0 to E0+2.
- timeout_err updates on the same edge as the state exit that causes it, and stays valid during the done pulse.

## Structure
- Shared package amcxfif_pkg holds:
  - state encoding localparams (3-bit, IDLE=0);
  - the default HOLD_CYC and TIMEOUT_CYC constants;
  - the domain-index constants for NUM_DOM=5.
- One sub-module, amcxfif_sync: a SYNC_STAGES-deep vector bit synchronizer, width NUM_DOM, reset to 0 by hresetn, producing ack_sync.
- The FSM, hold counter, timeout counter and mask register stay in amcxfif_rstseq.

## Test plan
- Loopback ack=soft_rst_o, mask=5'b10101, HOLD_CYC=16 → soft_rst_o=10101 for exactly 19 cycles; done at E0+22; timeout_err=0.
- Domain 2 ack stuck low, TIMEOUT_CYC=8 → soft_rst_o released after 8 WAIT_SET cycles; timeout_err=1; done pulse; next accepted request clears timeout_err.
- rst_mask=0 → no soft_rst_o activity; done at E0+1.
- rst_req held high through a sequence plus a mask change mid-sequence → original mask used throughout; a second sequence starts on the first IDLE cycle after done.
- hresetn pulsed low during HOLD → all outputs 0 immediately; after reset release, FSM in IDLE and accepts a new request normally.
- Unmasked ack bits toggling randomly during a mask=5'b00001 sequence → timing identical to the clean loopback case.

Source files
------------

// File: rtl/amcxfif_pkg.sv
// Shared definitions for the FIFO clock/reset soft-reset path.
package amcxfif_pkg;

   // State encodings. IDLE must stay zero so a cleared register means idle.
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_SET = 3'd1;
   localparam logic [2:0] ST_HOLD     = 3'd2;
   localparam logic [2:0] ST_WAIT_CLR = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      WAIT_SET = ST_WAIT_SET,
      HOLD     = ST_HOLD,
      WAIT_CLR = ST_WAIT_CLR,
      DONE     = ST_DONE
   } rstseq_state_e;

   // Default sequencing parameters.
   localparam int DEF_NUM_DOM     = 5;
   localparam int DEF_HOLD_CYC    = 16;
   localparam int DEF_TIMEOUT_CYC = 1023;
   localparam int DEF_SYNC_STAGES = 2;

   // Bit positions of the reset domains when NUM_DOM is 5.
   localparam int DOM_RX_SYS = 0;
   localparam int DOM_TX_SYS = 1;
   localparam int DOM_RX_FAB = 2;
   localparam int DOM_TX_FAB = 3;
   localparam int DOM_STATS  = 4;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/amcxfif_sync.sv
// Multi-flop vector synchronizer bringing the domain reset echoes onto hclk.
module amcxfif_sync
   import amcxfif_pkg::*;
#(
   parameter int WIDTH  = DEF_NUM_DOM,
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [STAGES-1:0][WIDTH-1:0] sync_d;

   // Shift the raw input one stage deeper every cycle; stage 0 takes the input.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   // Synchronizer flops, cleared by the host reset.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/amcxfif_rstseq.sv
// Soft-reset sequencer: asserts per-domain soft resets, waits for each domain's
// synchronized reset to echo asserted and then released, and reports completion
// or timeout to the host.
module amcxfif_rstseq
   import amcxfif_pkg::*;
#(
   parameter int NUM_DOM     = DEF_NUM_DOM,
   parameter int HOLD_CYC    = DEF_HOLD_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic               hclk,
   input  logic               hresetn,
   input  logic               rst_req,
   input  logic [NUM_DOM-1:0] rst_mask,
   output logic [NUM_DOM-1:0] soft_rst_o,
   input  logic [NUM_DOM-1:0] dom_rst_ack,
   output logic               busy,
   output logic               done,
   output logic               timeout_err
);

   localparam int HOLD_W = cnt_width(HOLD_CYC - 1);
   localparam int TMO_W  = cnt_width(TIMEOUT_CYC);

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
   localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

   rstseq_state_e      state_q, state_d;
   logic [NUM_DOM-1:0] mask_q, mask_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [NUM_DOM-1:0] soft_rst_q, soft_rst_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               tmo_err_q, tmo_err_d;

   logic [NUM_DOM-1:0] ack_sync;
   logic               set_met;
   logic               clr_met;
   logic               tmo_hit;
   logic               in_wait;
   logic               enter_wait;

   amcxfif_sync #(
      .WIDTH  (NUM_DOM),
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .hclk    (hclk),
      .hresetn (hresetn),
      .d_i     (dom_rst_ack),
      .q_o     (ack_sync)
   );

   // Next-state logic; only masked ack bits take part in any decision.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      hold_d    = hold_q;
      tmo_err_d = tmo_err_q;
      set_met   = ((ack_sync & mask_q) == mask_q);
      clr_met   = ((ack_sync & mask_q) == '0);
      tmo_hit   = (tmo_q >= TMO_LAST);
      case (state_q)
         IDLE: begin
            if (rst_req) begin
               mask_d    = rst_mask;
               tmo_err_d = 1'b0;
               state_d   = WAIT_SET;
            end
         end
         WAIT_SET: begin
            if (mask_q == '0) begin
               state_d = DONE;
            end else if (set_met) begin
               state_d = HOLD;
               hold_d  = HOLD_LOAD;
            end else if (tmo_hit) begin
               tmo_err_d = 1'b1;
               state_d   = WAIT_CLR;
            end
         end
         HOLD: begin
            if (hold_q == '0) begin
               state_d = WAIT_CLR;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         WAIT_CLR: begin
            if (clr_met) begin
               state_d = DONE;
            end else if (tmo_hit) begin
               tmo_err_d = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Shared wait timer: cleared whenever a wait state is entered, counts while
   // waiting and parks at TIMEOUT_CYC instead of wrapping.
   always_comb begin
      in_wait    = (state_q == WAIT_SET) || (state_q == WAIT_CLR);
      enter_wait = ((state_d == WAIT_SET) || (state_d == WAIT_CLR)) && (state_d != state_q);
      tmo_d      = tmo_q;
      if (enter_wait) begin
         tmo_d = '0;
      end else if (in_wait && (tmo_q != TMO_MAX)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   // Moore outputs decoded from the upcoming state so they leave a flop.
   always_comb begin
      soft_rst_d = '0;
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      if ((state_d == WAIT_SET) || (state_d == HOLD)) begin
         soft_rst_d = mask_d;
      end
   end

   // State, counters, mask and output registers.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         hold_q     <= '0;
         tmo_q      <= '0;
         soft_rst_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tmo_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         hold_q     <= hold_d;
         tmo_q      <= tmo_d;
         soft_rst_q <= soft_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tmo_err_q  <= tmo_err_d;
      end
   end

   assign soft_rst_o  = soft_rst_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_amcxfif_rstseq.sv
// Self-checking bench for the soft-reset sequencer (HOLD_CYC=16, TIMEOUT_CYC=8).
module tb_amcxfif_rstseq;

   localparam int ND = 5;
   localparam int HC = 16;
   localparam int TC = 8;
   localparam int SS = 2;
   localparam int WINDOW = 30;

   typedef struct {
      logic [ND-1:0] mask;
      logic [ND-1:0] stuck;
      bit            noise;
      int            exp_high;
      int            exp_done;
      int            exp_busy;
      bit            exp_tmo;
   } vec_t;

   logic          hclk = 1'b0;
   logic          hresetn = 1'b0;
   logic          rst_req = 1'b0;
   logic [ND-1:0] rst_mask = '0;
   logic [ND-1:0] soft_rst_o;
   logic [ND-1:0] dom_rst_ack;
   logic          busy;
   logic          done;
   logic          timeout_err;
   logic [ND-1:0] stuck_v = '0;
   logic [ND-1:0] noise_v = '0;

   int   passes = 0;
   int   total = 0;
   vec_t sb_q[$];
   vec_t vecs[6];

   amcxfif_rstseq #(
      .NUM_DOM     (ND),
      .HOLD_CYC    (HC),
      .TIMEOUT_CYC (TC),
      .SYNC_STAGES (SS)
   ) dut (
      .hclk        (hclk),
      .hresetn     (hresetn),
      .rst_req     (rst_req),
      .rst_mask    (rst_mask),
      .soft_rst_o  (soft_rst_o),
      .dom_rst_ack (dom_rst_ack),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err)
   );

   // Free-running host clock.
   always #5 hclk = ~hclk;

   // Zero-delay loopback of the soft resets, with stuck-low bits and optional noise.
   assign dom_rst_ack = (soft_rst_o & ~stuck_v) | noise_v;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Launch one sequence from a table entry and score it over a fixed window.
   task automatic applyStimulus(input int idx, input vec_t v);
      vec_t exp;
      int   high = 0, busyc = 0, donec = 0, bad = 0;
      bit   popped = 0;
      stuck_v = v.stuck;
      noise_v = '0;
      @(negedge hclk);
      rst_mask = v.mask;
      rst_req  = 1'b1;
      sb_q.push_back(v);
      @(posedge hclk);
      #1 rst_req = 1'b0;
      for (int n = 0; n < WINDOW; n++) begin
         @(negedge hclk);
         if (n == 0) checkOutput($sformatf("v%0d_tmo_cleared", idx), timeout_err, 0);
         if (soft_rst_o != '0) begin
            high++;
            if (soft_rst_o != v.mask) bad++;
         end
         if (busy) busyc++;
         if (done) begin
            donec++;
            if (!popped) begin
               exp = sb_q.pop_front();
               popped = 1;
               checkOutput($sformatf("v%0d_done_at", idx), n, exp.exp_done);
               checkOutput($sformatf("v%0d_tmo_err", idx), timeout_err, exp.exp_tmo);
            end
         end
         if (v.noise) noise_v = ND'($urandom) & ~v.mask;
      end
      noise_v = '0;
      if (!popped) begin
         exp = sb_q.pop_front();
         checkOutput($sformatf("v%0d_done_seen", idx), 0, 1);
      end
      checkOutput($sformatf("v%0d_soft_cycles", idx), high, exp.exp_high);
      checkOutput($sformatf("v%0d_soft_wrong", idx), bad, 0);
      checkOutput($sformatf("v%0d_busy_cycles", idx), busyc, exp.exp_busy);
      checkOutput($sformatf("v%0d_done_width", idx), donec, 1);
   endtask

   initial begin
      int   dfirst;
      int   bad;
      vec_t lb;

      // {mask, stuck, noise, soft cycles, done offset, busy cycles, timeout}
      vecs[0] = '{5'b10101, 5'b00000, 1'b0, 19, 22, 23, 1'b0};
      vecs[1] = '{5'b10101, 5'b00100, 1'b0,  8, 11, 12, 1'b1};
      vecs[2] = '{5'b00000, 5'b00000, 1'b0,  0,  1,  2, 1'b0};
      vecs[3] = '{5'b00001, 5'b00000, 1'b1, 19, 22, 23, 1'b0};
      vecs[4] = '{5'b00100, 5'b00100, 1'b0,  8,  9, 10, 1'b1};
      vecs[5] = '{5'b11111, 5'b00000, 1'b0, 19, 22, 23, 1'b0};

      repeat (3) @(negedge hclk);
      checkOutput("rst_soft", soft_rst_o, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_tmo", timeout_err, 0);
      hresetn = 1'b1;
      repeat (2) @(negedge hclk);

      for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

      // rst_req held high, mask changed mid-sequence, back-to-back restart.
      stuck_v = '0;
      @(negedge hclk);
      rst_mask = 5'b10101;
      rst_req  = 1'b1;
      @(posedge hclk);
      dfirst = -1;
      bad = 0;
      for (int n = 0; n < 26; n++) begin
         @(negedge hclk);
         if (n <= 22 && soft_rst_o != '0 && soft_rst_o != 5'b10101) bad++;
         if (done && dfirst < 0) dfirst = n;
         if (n == 5) rst_mask = 5'b00011;
         if (n == 23) checkOutput("held_busy_gap", busy, 0);
         if (n == 24) begin
            checkOutput("held_restart_soft", soft_rst_o, 5'b00011);
            checkOutput("held_restart_busy", busy, 1);
            rst_req = 1'b0;
         end
      end
      checkOutput("held_mask_kept", bad, 0);
      checkOutput("held_done_at", dfirst, 22);
      for (int i = 0; i < 60 && busy; i++) @(negedge hclk);
      checkOutput("held_second_idle", busy, 0);

      // Asynchronous reset pulsed while in HOLD.
      @(negedge hclk);
      rst_mask = 5'b10101;
      rst_req  = 1'b1;
      @(posedge hclk);
      #1 rst_req = 1'b0;
      repeat (11) @(negedge hclk);
      checkOutput("hold_soft_before", soft_rst_o, 5'b10101);
      #2 hresetn = 1'b0;
      #1;
      checkOutput("arst_soft", soft_rst_o, 0);
      checkOutput("arst_busy", busy, 0);
      checkOutput("arst_done", done, 0);
      @(negedge hclk);
      hresetn = 1'b1;
      @(negedge hclk);
      checkOutput("arst_idle_busy", busy, 0);
      lb = vecs[0];
      applyStimulus(6, lb);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
